// File: rtl/clk_reset_seq.sv
// clk_reset_seq
//   Releases a vector of per-block active-low resets in a fixed order with a
//   programmable gap. It then runs a divided clock-enable strobe until a soft
//   reset request re-runs the sequence.
//   Optional feature macro: RSTSEQ_WDOG_EN adds a heartbeat watchdog whose
//   expiry triggers the same soft-reset path. Without it, heartbeat is ignored
//   and wdog_trip is tied low.
module clk_reset_seq #(
  parameter int STAGES     = 4,
  parameter int GAP        = 8,
  parameter int DIV        = 2,
  parameter int SOFT_HOLD  = 4,
  parameter int WDOG_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              soft_req,
  input  logic              heartbeat,
  output logic [STAGES-1:0] rst_stage_l,
  output logic              running,
  output logic              clk_en,
  output logic              soft_ack,
  output logic              wdog_trip
);

  // SOFT counts its entry cycle plus SOFT_HOLD full hold cycles, so its limit
  // is SOFT_HOLD rather than SOFT_HOLD-1.
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = $clog2(SOFT_HOLD + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SOFT_HOLD);
  localparam logic [STAGES-1:0] STAGE_LSB = STAGES'(1);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                rst_meta;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [STAGES-1:0]   stage_d;
  logic                clk_en_d;
  logic                soft_ack_d;
  logic                wdog_expire;

  // Registered state, counters and outputs. The reset synchronizer's first
  // flop is rst_meta. The state register is its second stage: it leaves
  // RESET on the edge after rst_meta has captured the released reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rst_meta    <= 1'b0;
      state_q     <= ST_RESET;
      gap_q       <= '0;
      div_q       <= '0;
      hold_q      <= '0;
      rst_stage_l <= '0;
      running     <= 1'b0;
      clk_en      <= 1'b0;
      soft_ack    <= 1'b0;
    end else begin
      rst_meta    <= 1'b1;
      state_q     <= state_d;
      gap_q       <= gap_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      rst_stage_l <= stage_d;
      running     <= (state_d == ST_RUN);
      clk_en      <= clk_en_d;
      soft_ack    <= soft_ack_d;
    end
  end

  // Next-state, counter and output-next logic for the sequencer.
  // NOTE: every signal gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    gap_d      = '0;
    div_d      = '0;
    hold_d     = '0;
    stage_d    = '0;
    clk_en_d   = 1'b0;
    soft_ack_d = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (rst_meta) state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        // Bits are only ever added here, lowest stage first.
        stage_d = rst_stage_l;
        if (gap_q == GAP_LAST) begin
          stage_d = (rst_stage_l << 1) | STAGE_LSB;
          if (&stage_d) state_d = ST_RUN;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (soft_req || wdog_expire) begin
          state_d    = ST_SOFT;
          soft_ack_d = soft_req;
        end else begin
          stage_d = '1;
          if (div_q == DIV_LAST) clk_en_d = 1'b1;
          else                   div_d    = div_q + 1'b1;
        end
      end

      ST_SOFT: begin
        if (hold_q == HOLD_LAST) state_d = ST_RELEASE;
        else                     hold_d  = hold_q + 1'b1;
      end

      default: state_d = ST_RESET;
    endcase
  end

`ifdef RSTSEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  logic [WDOG_W-1:0] wdog_q;

  assign wdog_expire = (state_q == ST_RUN) && !heartbeat && (wdog_q == WDOG_LAST);

  // Watchdog: counts quiet RUN cycles. It clears on heartbeat, on expiry and
  // whenever the FSM is outside RUN, so every RUN entry starts from zero.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wdog_q    <= '0;
      wdog_trip <= 1'b0;
    end else begin
      wdog_trip <= wdog_expire;
      if ((state_q != ST_RUN) || heartbeat || wdog_expire) wdog_q <= '0;
      else                                                 wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  // Watchdog absent: heartbeat and WDOG_LIMIT are deliberately unused.
  logic unused_wdog;
  assign unused_wdog = heartbeat | (WDOG_LIMIT < 2);
  assign wdog_expire = 1'b0;
  assign wdog_trip   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_reset_seq.sv
// tb_clk_reset_seq
//   Checks clk_reset_seq against a cycle-count model of the sequencing rules.
//   The model tracks elapsed cycles since each phase began and derives the
//   expected outputs arithmetically. Directed phases pin absolute latencies.
//   A randomized phase then mixes soft requests, heartbeats and mid-cycle
//   asynchronous resets. Build with +define+RSTSEQ_WDOG_EN for the watchdog
//   variant.
module tb_clk_reset_seq;

  localparam int STAGES     = 4;
  localparam int GAP        = 8;
  localparam int DIV        = 2;
  localparam int SOFT_HOLD  = 4;
  localparam int WDOG_LIMIT = 16;
`ifdef RSTSEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              reset_l   = 1'b1;
  logic              soft_req  = 1'b0;
  logic              heartbeat = 1'b1;
  logic [STAGES-1:0] rst_stage_l;
  logic              running;
  logic              clk_en;
  logic              soft_ack;
  logic              wdog_trip;

  int tests  = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  clk_reset_seq #(
    .STAGES    (STAGES),
    .GAP       (GAP),
    .DIV       (DIV),
    .SOFT_HOLD (SOFT_HOLD),
    .WDOG_LIMIT(WDOG_LIMIT)
  ) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .soft_req   (soft_req),
    .heartbeat  (heartbeat),
    .rst_stage_l(rst_stage_l),
    .running    (running),
    .clk_en     (clk_en),
    .soft_ack   (soft_ack),
    .wdog_trip  (wdog_trip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Phases are tracked by elapsed edge counts. Expected outputs follow from
  // how many cycles have passed since each phase started.
  typedef enum {M_WAIT, M_REL, M_RUN, M_SOFT} mphase_t;
  mphase_t           ph         = M_WAIT;
  int                since_rise = 0;
  int                rel_t      = 0;
  int                run_t      = 0;
  int                soft_t     = 0;
  int                quiet      = 0;
  logic [STAGES-1:0] m_stage    = '0;
  bit                m_run      = 1'b0;
  bit                m_en       = 1'b0;
  bit                m_ack      = 1'b0;
  bit                m_trip     = 1'b0;

  task automatic model_clear();
    ph         = M_WAIT;
    since_rise = 0;
    m_stage    = '0;
    m_run      = 1'b0;
    m_en       = 1'b0;
    m_ack      = 1'b0;
    m_trip     = 1'b0;
  endtask

  always @(negedge reset_l) model_clear();

  always @(posedge clk) begin : model
    int n;
    bit expire;
    if (!reset_l) begin
      model_clear();
    end else begin
      m_en   = 1'b0;
      m_ack  = 1'b0;
      m_trip = 1'b0;
      case (ph)
        M_WAIT: begin
          since_rise++;
          if (since_rise == 2) begin ph = M_REL; rel_t = 0; end
        end
        M_REL: begin
          rel_t++;
          n = rel_t / GAP;
          if (n >= STAGES) begin
            ph = M_RUN; run_t = 0; quiet = 0; m_stage = '1; m_run = 1'b1;
          end else begin
            m_stage = STAGES'((1 << n) - 1);
          end
        end
        M_RUN: begin
          expire = WDOG_ON && !heartbeat && (quiet == WDOG_LIMIT - 1);
          if (soft_req || expire) begin
            ph = M_SOFT; soft_t = 0;
            m_ack = soft_req; m_trip = expire;
            m_stage = '0; m_run = 1'b0;
          end else begin
            run_t++;
            m_en  = ((run_t % DIV) == 0);
            quiet = heartbeat ? 0 : quiet + 1;
          end
        end
        M_SOFT: begin
          soft_t++;
          if (soft_t == SOFT_HOLD + 1) begin ph = M_REL; rel_t = 0; end
        end
      endcase
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rst_stage_l", rst_stage_l, m_stage);
      check("cyc_running",     running,     m_run);
      check("cyc_clk_en",      clk_en,      m_en);
      check("cyc_soft_ack",    soft_ack,    m_ack);
      check("cyc_wdog_trip",   wdog_trip,   m_trip);
    end
  end

  task automatic wait_running(input string name);
    for (int i = 0; i < 80; i++) begin
      if (running === 1'b1) break;
      tick();
    end
    check(name, running, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_rel[STAGES] = '{10, 18, 26, 34};
    int first_stage[STAGES];
    int first_run, first_en, first_ack, first_s0, en_cnt, ack_cnt, found, restart_val;

    #1 reset_l = 1'b0;
    #1 chk_en  = 1'b1;
    check("reset_stage",   rst_stage_l, 0);
    check("reset_running", running,     0);
    check("reset_clk_en",  clk_en,      0);
    repeat (5) tick();

    // Power-on release and the first 20 RUN cycles.
    reset_l = 1'b1;
    foreach (first_stage[k]) first_stage[k] = -1;
    first_run = -1; first_en = -1; en_cnt = 0;
    for (int i = 1; i <= 54; i++) begin
      tick();
      for (int k = 0; k < STAGES; k++)
        if (first_stage[k] < 0 && rst_stage_l[k] === 1'b1) first_stage[k] = i;
      if (first_run < 0 && running === 1'b1) first_run = i;
      if (first_en  < 0 && clk_en  === 1'b1) first_en  = i;
      if (i >= 35 && clk_en === 1'b1) en_cnt++;
    end
    for (int k = 0; k < STAGES; k++)
      check($sformatf("stage%0d_release_edge", k), first_stage[k], exp_rel[k]);
    check("power_on_latency",    first_run, 34);
    check("first_clk_en_edge",   first_en,  36);
    check("clk_en_pulses_20cyc", en_cnt,    10);

    // One-cycle soft request in RUN.
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    check("soft_ack_pulse",   soft_ack,    1);
    check("soft_stage_low",   rst_stage_l, 0);
    check("soft_running_low", running,     0);
    ack_cnt = 0; first_s0 = -1; first_run = -1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (soft_ack === 1'b1) ack_cnt++;
      if (first_s0  < 0 && rst_stage_l[0] === 1'b1) first_s0  = i;
      if (first_run < 0 && running        === 1'b1) first_run = i;
    end
    check("soft_ack_width",        ack_cnt,   0);
    check("soft_first_stage_edge", first_s0,  13);
    check("soft_latency",          first_run, 37);

    // Asynchronous reset while rst_stage_l = 0011.
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    found = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rst_stage_l === 4'b0011) begin found = i; break; end
    end
    check("reach_0011_edge", found, 21);
    #2 reset_l = 1'b0;
    #1;
    check("async_clear_stage",   rst_stage_l, 0);
    check("async_clear_running", running,     0);
    tick(); tick();
    reset_l = 1'b1;
    found = -1; restart_val = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rst_stage_l !== 4'b0000) begin found = i; restart_val = int'(rst_stage_l); break; end
    end
    check("restart_edge",  found,       10);
    check("restart_value", restart_val, 1);

    // Soft request held through RELEASE is taken on the first RUN edge.
    soft_req = 1'b1;
    first_run = -1; first_ack = -1;
    for (int i = 11; i <= 60; i++) begin
      tick();
      if (first_run < 0 && running  === 1'b1) first_run = i;
      if (first_ack < 0 && soft_ack === 1'b1) begin first_ack = i; break; end
    end
    soft_req = 1'b0;
    check("held_req_run_edge", first_run, 34);
    check("held_req_ack_edge", first_ack, 35);
    wait_running("rerun_after_held_req");

`ifdef RSTSEQ_WDOG_EN
    begin : wdog_directed
      int trip_cnt, first_trip, wd_ack;
      trip_cnt = 0;
      for (int i = 0; i < 200; i++) begin
        heartbeat = (i % 10 == 0);
        tick();
        if (wdog_trip === 1'b1) trip_cnt++;
      end
      check("wdog_no_trip_200", trip_cnt, 0);
      heartbeat = 1'b1; tick(); heartbeat = 1'b0;
      first_trip = -1; first_run = -1; wd_ack = 0;
      for (int i = 1; i <= 60; i++) begin
        tick();
        if (soft_ack === 1'b1) wd_ack++;
        if (first_trip < 0 && wdog_trip === 1'b1) first_trip = i;
        if (first_trip > 0 && first_run < 0 && running === 1'b1) first_run = i - first_trip;
      end
      check("wdog_trip_edge",    first_trip, 16);
      check("wdog_soft_ack_low", wd_ack,     0);
      check("wdog_rerun_lat",    first_run,  37);
      heartbeat = 1'b1;
    end
`else
    begin : no_wdog_directed
      int drops, trip_cnt;
      drops = 0; trip_cnt = 0;
      heartbeat = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (running   !== 1'b1) drops++;
        if (wdog_trip !== 1'b0) trip_cnt++;
      end
      check("no_wdog_running_kept", drops,    0);
      check("no_wdog_trip_low",     trip_cnt, 0);
    end
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      soft_req  = ($urandom_range(0, 39) == 0);
      heartbeat = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 249) == 0) begin
        case ($urandom_range(1, 3))
          1:       #1;
          2:       #2;
          default: #3;
        endcase
        reset_l = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        reset_l = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
